// File: rtl/irq_sched.sv
// irq_sched: edge-capturing interrupt scheduler driving the LEGv8 ExtIRQ/ExtIAck/ERet handshake.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority (index 0 highest).
module irq_sched #(
    parameter int NSRC = 8,
    parameter int IDW  = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            ExtIAck,
    input  logic            ERet,
    output logic            ExtIRQ,
    output logic [IDW-1:0]  irq_id,
    output logic [NSRC-1:0] irq_ack,
    output logic            irq_active,
    output logic [NSRC-1:0] pending
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] grant_clr;
    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  win_id;
    logic            win_valid;

    assign edge_set  = irq_src & ~src_q;
    assign eligible  = pending & mask;
    assign grant_clr = (state == REQ && ExtIAck)
                       ? ({{(NSRC-1){1'b0}}, 1'b1} << sel_id) : '0;
    assign irq_id    = sel_id;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IDW-1:0]  rr_ptr;
    logic [NSRC-1:0] rotated;

    // Rotate so rr_ptr lands at bit 0, pick the lowest set bit, then rotate the index back.
    assign rotated = NSRC'({eligible, eligible} >> rr_ptr);

    always_comb begin
        int sum;
        win_valid = 1'b0;
        win_id    = '0;
        sum       = 0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                win_valid = 1'b1;
                sum       = int'(rr_ptr) + i;
                if (sum >= NSRC) sum = sum - NSRC;
                win_id    = IDW'(sum);
            end
        end
    end
`else
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_valid = 1'b1;
                win_id    = IDW'(i);
            end
        end
    end
`endif

    // A fresh edge is OR-ed in after the grant clear so a same-cycle re-assertion survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ExtIRQ     <= 1'b0;
            sel_id     <= '0;
            irq_ack    <= '0;
            irq_active <= 1'b0;
            pending    <= '0;
            mask       <= '1;
            src_q      <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
            rr_ptr     <= '0;
`endif
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~grant_clr) | edge_set;
            irq_ack <= '0;
            if (mask_we) mask <= mask_wdata;

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        sel_id <= win_id;
                        ExtIRQ <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ExtIAck) begin
                        irq_ack    <= grant_clr;
                        ExtIRQ     <= 1'b0;
                        irq_active <= 1'b1;
                        state      <= SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
                        rr_ptr     <= (sel_id == IDW'(NSRC - 1)) ? '0 : sel_id + 1'b1;
`endif
                    end
                end
                SERVICE: begin
                    if (ERet) begin
                        irq_active <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// Directed testbench for irq_sched: handshake timing, priority, masking, merging and async reset.
module tb_irq_sched;

    localparam int NSRC = 8;
    localparam int IDW  = 3;

`ifdef IRQ_ROUND_ROBIN_EN
    localparam logic [2:0] FIRST_ID  = 3'd5;
    localparam logic [2:0] SECOND_ID = 3'd2;
`else
    localparam logic [2:0] FIRST_ID  = 3'd2;
    localparam logic [2:0] SECOND_ID = 3'd5;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            ExtIAck;
    logic            ERet;
    logic            ExtIRQ;
    logic [IDW-1:0]  irq_id;
    logic [NSRC-1:0] irq_ack;
    logic            irq_active;
    logic [NSRC-1:0] pending;

    int total = 0;
    int bad   = 0;

    irq_sched #(.NSRC(NSRC), .IDW(IDW)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_src    (irq_src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .ExtIAck    (ExtIAck),
        .ERet       (ERet),
        .ExtIRQ     (ExtIRQ),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_active (irq_active),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] src, input logic ack, input logic eret);
        irq_src = src;
        ExtIAck = ack;
        ERet    = eret;
        tick();
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick();
        mask_we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waited;
        logic [2:0] exp_id;

        reset      = 1'b0;
        irq_src    = '0;
        mask_we    = 1'b0;
        mask_wdata = '0;
        ExtIAck    = 1'b0;
        ERet       = 1'b0;
        #2;
        check_output("rst_extirq", ExtIRQ, 0);
        check_output("rst_id", irq_id, 0);
        check_output("rst_ack", irq_ack, 0);
        check_output("rst_active", irq_active, 0);
        check_output("rst_pending", pending, 0);
        tick();
        tick();
        reset = 1'b1;

        // Single source: two-cycle request latency, one-cycle ack pulse, ERet return
        apply_stimulus(8'h00, 0, 0);
        apply_stimulus(8'h00, 0, 0);
        apply_stimulus(8'h00, 0, 0);
        apply_stimulus(8'h08, 0, 0);
        check_output("t1_pending", pending, 8'h08);
        check_output("t1_extirq_early", ExtIRQ, 0);
        apply_stimulus(8'h08, 0, 0);
        check_output("t1_extirq", ExtIRQ, 1);
        check_output("t1_id", irq_id, 3);
        apply_stimulus(8'h08, 0, 0);
        check_output("t1_extirq_hold", ExtIRQ, 1);
        apply_stimulus(8'h08, 1, 0);
        check_output("t1_ack", irq_ack, 8'h08);
        check_output("t1_extirq_drop", ExtIRQ, 0);
        check_output("t1_active", irq_active, 1);
        check_output("t1_pending_clr", pending, 0);
        apply_stimulus(8'h08, 0, 0);
        check_output("t1_ack_pulse", irq_ack, 0);
        check_output("t1_active_hold", irq_active, 1);
        apply_stimulus(8'h08, 0, 1);
        check_output("t1_eret", irq_active, 0);
        apply_stimulus(8'h00, 0, 0);

        // Two simultaneous sources: priority order and the idle gap after ERet
        apply_stimulus(8'h24, 0, 0);
        check_output("t2_pending", pending, 8'h24);
        apply_stimulus(8'h24, 0, 0);
        check_output("t2_extirq", ExtIRQ, 1);
        check_output("t2_first_id", irq_id, FIRST_ID);
        apply_stimulus(8'h24, 1, 0);
        check_output("t2_first_ack", irq_ack, 8'h01 << FIRST_ID);
        apply_stimulus(8'h24, 0, 0);
        apply_stimulus(8'h24, 0, 1);
        check_output("t2_gap_extirq", ExtIRQ, 0);
        check_output("t2_gap_active", irq_active, 0);
        apply_stimulus(8'h24, 0, 0);
        check_output("t2_second_extirq", ExtIRQ, 1);
        check_output("t2_second_id", irq_id, SECOND_ID);
        apply_stimulus(8'h24, 1, 0);
        check_output("t2_second_ack", irq_ack, 8'h01 << SECOND_ID);
        check_output("t2_pending_empty", pending, 0);
        apply_stimulus(8'h00, 0, 1);

        // Masked source still latches pending; unmasking releases the request
        write_mask(8'hFE);
        apply_stimulus(8'h01, 0, 0);
        check_output("t3_pending", pending, 8'h01);
        apply_stimulus(8'h00, 0, 0);
        apply_stimulus(8'h00, 0, 0);
        check_output("t3_masked", ExtIRQ, 0);
        write_mask(8'hFF);
        check_output("t3_mask_edge", ExtIRQ, 0);
        apply_stimulus(8'h00, 0, 0);
        check_output("t3_unmasked", ExtIRQ, 1);
        check_output("t3_id", irq_id, 0);

        // Out-of-state handshakes ignored; repeated edges merge into one pending
        apply_stimulus(8'h00, 0, 1);
        check_output("t4_eret_req", ExtIRQ, 1);
        check_output("t4_eret_req_act", irq_active, 0);
        apply_stimulus(8'h00, 1, 0);
        check_output("t4_ack", irq_ack, 8'h01);
        apply_stimulus(8'h00, 1, 0);
        check_output("t4_ack_svc", irq_ack, 0);
        check_output("t4_ack_svc_act", irq_active, 1);
        check_output("t4_ack_svc_irq", ExtIRQ, 0);
        apply_stimulus(8'h02, 0, 0);
        apply_stimulus(8'h00, 0, 0);
        apply_stimulus(8'h02, 0, 0);
        apply_stimulus(8'h00, 0, 0);
        check_output("t4_merge", pending, 8'h02);
        apply_stimulus(8'h00, 0, 1);
        check_output("t4_ret", irq_active, 0);
        apply_stimulus(8'h00, 0, 0);
        check_output("t4_req1", ExtIRQ, 1);
        check_output("t4_id1", irq_id, 1);
        apply_stimulus(8'h00, 1, 0);
        check_output("t4_single", pending, 0);
        apply_stimulus(8'h00, 0, 1);
        apply_stimulus(8'h00, 1, 0);
        check_output("t4_ack_idle_irq", ExtIRQ, 0);
        check_output("t4_ack_idle_act", irq_active, 0);
        check_output("t4_ack_idle_pulse", irq_ack, 0);

        // Committed request survives masking; async reset aborts everything
        apply_stimulus(8'h10, 0, 0);
        apply_stimulus(8'h10, 0, 0);
        check_output("t5_req", ExtIRQ, 1);
        check_output("t5_id", irq_id, 4);
        irq_src = 8'h50;
        write_mask(8'hEF);
        check_output("t5_committed", ExtIRQ, 1);
        check_output("t5_pending", pending, 8'h50);
        #2;
        reset = 1'b0;
        #1;
        check_output("t5_rst_irq", ExtIRQ, 0);
        check_output("t5_rst_pending", pending, 0);
        check_output("t5_rst_id", irq_id, 0);
        reset = 1'b1;
        apply_stimulus(8'h50, 0, 0);
        check_output("t5_relatch", pending, 8'h50);
        apply_stimulus(8'h50, 0, 0);
        check_output("t5_mask_reset", irq_id, 4);
        check_output("t5_mask_reset_irq", ExtIRQ, 1);
        apply_stimulus(8'h50, 1, 0);
        check_output("t5_ack4", irq_ack, 8'h10);
        apply_stimulus(8'h50, 0, 1);
        apply_stimulus(8'h50, 0, 0);
        check_output("t5_id6", irq_id, 6);
        apply_stimulus(8'h50, 1, 0);
        apply_stimulus(8'h00, 0, 1);

        // Sources 0 and 1 re-pulsed after every grant
        apply_stimulus(8'h03, 0, 0);
        apply_stimulus(8'h00, 0, 0);
        for (int r = 0; r < 4; r++) begin
`ifdef IRQ_ROUND_ROBIN_EN
            exp_id = 3'(r % 2);
`else
            exp_id = 3'd0;
`endif
            waited = 0;
            while (ExtIRQ !== 1'b1 && waited < 8) begin
                apply_stimulus(8'h00, 0, 0);
                waited++;
            end
            check_output("t6_req", ExtIRQ, 1);
            check_output("t6_id", irq_id, exp_id);
            apply_stimulus(8'h00, 1, 0);
            check_output("t6_ack", irq_ack, 8'h01 << exp_id);
            apply_stimulus(8'h03, 0, 0);
            apply_stimulus(8'h00, 0, 0);
            apply_stimulus(8'h00, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_sched.md
Name: irq_sched

Overview:
Interrupt scheduler that sits in front of the exception logic of the single-cycle LEGv8 core. It collects NSRC external interrupt lines, latches edges as pending and applies a software-writable mask. It then arbitrates one winner and drives the core's ExtIRQ input, and sequences the handshake through ExtIAck (acceptance) and ERet (handler return). Only one interrupt is in service at a time; there is no nesting.

Parameters:
NSRC, 8, number of interrupt sources (2..16)
IDW, 3, width of irq_id; must be >= clog2(NSRC)

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low; asserted when 0
irq_src  in  NSRC  raw interrupt lines, level, synchronous to clk
mask_we  in  1  mask write strobe
mask_wdata  in  NSRC  new mask value; 1 = source enabled
ExtIAck  in  1  from controller: core has taken the external exception
ERet  in  1  from controller: ERET executing this cycle
ExtIRQ  out  1  request to controller, registered
irq_id  out  IDW  index of the granted/requested source
irq_ack  out  NSRC  one-hot, one-cycle pulse to the granted source
irq_active  out  1  a handler is in service
pending  out  NSRC  current pending vector, for debug/status read

Behaviour:
- Reset (reset=0, async): state IDLE; ExtIRQ=0, irq_id=0, irq_ack=0, irq_active=0, pending=0, mask=all ones, src_q=0, rr_ptr=0.
- Edge capture: src_q <= irq_src each cycle. pending[i] sets when irq_src[i] & ~src_q[i].
  - A line already high at reset release yields exactly one pending.
  - Masked sources still latch pending.
- eligible = pending & mask.
- Mask: mask <= mask_wdata on a clock edge with mask_we=1. The new mask affects arbitration from the next cycle.
- Arbitration: fixed priority, index 0 highest (see optional feature).
- FSM with states IDLE, REQ, SERVICE:
  - IDLE: if |eligible, latch winner into sel_id/irq_id, go to REQ, ExtIRQ=1 from the next cycle. Latency is 2 cycles from the rising edge on irq_src to ExtIRQ=1.
  - REQ: ExtIRQ=1; irq_id held stable. The request is committed and is not withdrawn if the source is later masked.
    - On ExtIAck=1: clear pending[sel_id], irq_ack[sel_id]=1 for exactly the next cycle, ExtIRQ=0 next cycle, go to SERVICE.
  - SERVICE: irq_active=1, ExtIRQ=0, irq_id held. On ERet=1, go to IDLE and irq_active=0 next cycle.
- ERet in IDLE or REQ is ignored. ExtIAck outside REQ is ignored.
- Same-cycle pending set and clear on one bit: set wins, so a new edge is not lost.
- SERVICE with ERet=1 and eligible nonzero: go to IDLE first. The next ExtIRQ rises 2 cycles after ERet (minimum one idle cycle).
- New edges during REQ/SERVICE only accumulate as pending. Repeated edges on an already-pending line merge into one pending.
- Reset mid-operation aborts to IDLE; all pending state is lost.

Optional Feature:
IRQ_ROUND_ROBIN_EN:
- Defined: rotating priority. Search starts at rr_ptr and wraps modulo NSRC. On each ExtIAck grant, rr_ptr <= (sel_id+1) mod NSRC.
- Undefined: fixed priority with index 0 highest; rr_ptr is absent.

Test Plan:
1. Release reset with irq_src=0, then raise irq_src[3] at cycle 5 -> pending[3]=1 at cycle 6, ExtIRQ=1 and irq_id=3 at cycle 7. ExtIAck at cycle 9 -> irq_ack=8'h08 for one cycle, ExtIRQ=0, irq_active=1. ERet at cycle 12 -> irq_active=0.
2. Raise irq_src[5] and irq_src[2] in the same cycle -> irq_id=2 granted first. After ERet, irq_id=5 is requested, with ExtIRQ rising 2 cycles after ERet.
3. Write mask=8'hFE, then pulse irq_src[0] -> pending[0]=1, ExtIRQ stays 0. Write mask=8'hFF -> ExtIRQ=1, irq_id=0 on the following cycle.
4. In SERVICE, pulse irq_src[1] twice -> a single pending[1]. Assert ExtIAck and ERet while not in the matching state -> no state change.
5. Assert reset=0 while in REQ -> ExtIRQ=0, pending=0, mask=8'hFF immediately, without waiting for a clock edge.
6. With IRQ_ROUND_ROBIN_EN, hold sources 0 and 1 re-pulsing after each grant -> grants alternate 0,1,0,1. Without the macro -> source 0 wins every round.
